// File: rtl/uart_rx_mem.sv
// Memory-mapped UART receiver: 16x oversampled 8N1 deframer, receive FIFO,
// and RXDATA/STATUS/CTRL registers on the dmem bus.
module uart_rx_mem #(
  parameter int unsigned CLKS_PER_SAMPLE = 10,
  parameter int unsigned FIFO_LOG2       = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic [3:0]  writeb,
  input  logic        read,
  input  logic [5:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int unsigned TW    = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam int unsigned DEPTH = 1 << FIFO_LOG2;
  localparam int unsigned CW    = FIFO_LOG2 + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t               state, state_n;
  logic [TW-1:0]        tick_cnt;
  logic                 tick_c;
  logic                 rx_m, rx_s;
  logic [3:0]           scnt;
  logic [2:0]           bit_idx;
  logic [7:0]           shreg;
  logic                 scnt_clr_c, scnt_inc_c, bit_clr_c, shift_c, push_c, ferr_set_c;

  logic [7:0]           mem [DEPTH];
  logic [FIFO_LOG2-1:0] wptr, rptr;
  logic [CW-1:0]        count;
  logic                 en, ie, overrun, ferr;
  logic                 empty_c, full_c, pop_c, push_ok_c, ovr_set_c;
  logic                 ctrl_wr_c, stat_wr_c, flush_c;
  logic [31:0]          status_c;
  logic                 unused_ok_c;

  assign unused_ok_c = ^{wdata[31:4], writeb[3:1]};

  // Free-running sample tick and rx synchronizer
  assign tick_c = (tick_cnt == TW'(CLKS_PER_SAMPLE - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      rx_m     <= 1'b1;
      rx_s     <= 1'b1;
    end else begin
      tick_cnt <= tick_c ? '0 : tick_cnt + TW'(1);
      rx_m     <= rx;
      rx_s     <= rx_m;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // FSM next state
  always_comb begin
    state_n = state;
    if (!en) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (!rx_s) state_n = S_START;
        S_START: if (tick_c && scnt == 4'd7) state_n = rx_s ? S_IDLE : S_DATA;
        S_DATA:  if (tick_c && scnt == 4'd15 && bit_idx == 3'd7) state_n = S_STOP;
        S_STOP:  if (tick_c && scnt == 4'd15) state_n = rx_s ? S_IDLE : S_BREAK;
        S_BREAK: if (rx_s) state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // FSM outputs; gated by en so a disabled receiver never pushes
  always_comb begin
    scnt_clr_c = 1'b0;
    scnt_inc_c = 1'b0;
    bit_clr_c  = 1'b0;
    shift_c    = 1'b0;
    push_c     = 1'b0;
    ferr_set_c = 1'b0;
    if (en) begin
      case (state)
        S_IDLE: begin
          scnt_clr_c = 1'b1;
          bit_clr_c  = 1'b1;
        end
        S_START: if (tick_c) begin
          if (scnt == 4'd7) scnt_clr_c = 1'b1;
          else              scnt_inc_c = 1'b1;
        end
        S_DATA: if (tick_c) begin
          if (scnt == 4'd15) begin
            scnt_clr_c = 1'b1;
            shift_c    = 1'b1;
          end else begin
            scnt_inc_c = 1'b1;
          end
        end
        S_STOP: if (tick_c) begin
          if (scnt == 4'd15) begin
            push_c     = rx_s;
            ferr_set_c = ~rx_s;
          end else begin
            scnt_inc_c = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Deframer datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      scnt    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (scnt_clr_c)      scnt <= '0;
      else if (scnt_inc_c) scnt <= scnt + 4'd1;
      if (bit_clr_c) begin
        bit_idx <= '0;
      end else if (shift_c) begin
        bit_idx <= bit_idx + 3'd1;
        shreg   <= {rx_s, shreg[7:1]};
      end
    end
  end

  assign empty_c   = (count == '0);
  assign full_c    = (count == CW'(DEPTH));
  assign pop_c     = read && (addr == 6'd0) && !empty_c;
  assign ctrl_wr_c = writeb[0] && (addr == 6'd2);
  assign stat_wr_c = writeb[0] && (addr == 6'd1);
  assign flush_c   = ctrl_wr_c && wdata[2];
  assign push_ok_c = push_c && (!full_c || pop_c) && !flush_c;
  assign ovr_set_c = push_c && full_c && !pop_c && !flush_c;

  always_comb begin
    status_c          = '0;
    status_c[0]       = ~empty_c;
    status_c[1]       = full_c;
    status_c[2]       = overrun;
    status_c[3]       = ferr;
    status_c[8 +: CW] = count;
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wptr] <= shreg;
  end

  // FIFO pointers, status/control registers, read port
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      en      <= 1'b1;
      ie      <= 1'b0;
      overrun <= 1'b0;
      ferr    <= 1'b0;
      irq     <= 1'b0;
      rdata   <= '0;
    end else begin
      if (flush_c) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push_ok_c) wptr <= wptr + FIFO_LOG2'(1);
        if (pop_c)     rptr <= rptr + FIFO_LOG2'(1);
        case ({push_ok_c, pop_c})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: ;
        endcase
      end
      overrun <= ovr_set_c  | (overrun & ~(stat_wr_c & wdata[2]));
      ferr    <= ferr_set_c | (ferr    & ~(stat_wr_c & wdata[3]));
      if (ctrl_wr_c) begin
        en <= wdata[0];
        ie <= wdata[1];
      end
      irq <= ~empty_c & ie;
      if (read) begin
        case (addr)
          6'd0:    rdata <= empty_c ? 32'd0 : {23'd0, 1'b1, mem[rptr]};
          6'd1:    rdata <= status_c;
          6'd2:    rdata <= {30'd0, ie, en};
          default: rdata <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_mem.sv
// Directed bench for uart_rx_mem: frames driven on rx, registers checked via the bus.
module tb_uart_rx_mem;

  localparam int unsigned CPS = 4;
  localparam int unsigned BIT = 16 * CPS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic [3:0]  writeb = '0;
  logic        read = 1'b0;
  logic [5:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int failures = 0;

  uart_rx_mem #(.CLKS_PER_SAMPLE(CPS), .FIFO_LOG2(3)) dut (
    .clk(clk), .rst(rst), .rx(rx), .writeb(writeb), .read(read),
    .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a;
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = rdata;
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [31:0] wd);
    @(negedge clk);
    addr   = a;
    wdata  = wd;
    writeb = 4'h1;
    @(negedge clk);
    writeb = 4'h0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_low);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    if (stop_low) begin
      rx = 1'b0;
      repeat (2 * BIT) @(negedge clk);
    end
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  // Returns at the negedge before the edge on which a byte is pushed
  task automatic wait_push(output bit found);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (dut.push_c) found = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] d;
    bit found;

    repeat (5) @(negedge clk);
    check("reset_rdata", rdata, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    bus_read(6'd2, d); check("reset_ctrl", d, 32'h1);
    bus_read(6'd1, d); check("reset_status", d, 32'h0);

    // Single byte
    send_byte(8'hA5, 1'b0);
    bus_read(6'd1, d); check("a5_status", d, 32'h101);
    bus_read(6'd0, d); check("a5_rxdata", d, 32'h1A5);
    bus_read(6'd1, d); check("a5_status_after", d, 32'h0);

    // Short low glitch is rejected
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    bus_read(6'd1, d); check("glitch_status", d, 32'h0);

    // Fill and overrun
    for (int i = 0; i < 8; i++) send_byte(8'(i), 1'b0);
    bus_read(6'd1, d); check("full_status", d, 32'h803);
    send_byte(8'h08, 1'b0);
    bus_read(6'd1, d); check("overrun_status", d, 32'h807);
    for (int i = 0; i < 8; i++) begin
      bus_read(6'd0, d); check($sformatf("drain_%0d", i), d, 32'h100 + 32'(i));
    end
    bus_read(6'd0, d); check("drain_empty", d, 32'h0);
    bus_read(6'd1, d); check("overrun_sticky", d, 32'h4);
    bus_write(6'd1, 32'h4);
    bus_read(6'd1, d); check("overrun_clear", d, 32'h0);

    // Framing error, break, recovery
    send_byte(8'h3C, 1'b1);
    bus_read(6'd1, d); check("ferr_status", d, 32'h8);
    bus_write(6'd1, 32'h8);
    bus_read(6'd1, d); check("ferr_clear", d, 32'h0);
    send_byte(8'h7E, 1'b0);
    bus_read(6'd0, d); check("after_ferr_rxdata", d, 32'h17E);

    // Read coincident with push into a full FIFO
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b0);
    bus_read(6'd1, d); check("full2_status", d, 32'h803);
    fork
      send_byte(8'h55, 1'b0);
      begin
        wait_push(found);
        check("coinc_push_seen", {31'd0, found}, 32'h1);
        addr = 6'd0;
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        check("coinc_rxdata", rdata, 32'h110);
      end
    join
    bus_read(6'd1, d); check("coinc_status", d, 32'h803);
    for (int i = 1; i < 8; i++) begin
      bus_read(6'd0, d); check($sformatf("drain2_%0d", i), d, 32'h110 + 32'(i));
    end
    bus_read(6'd0, d); check("drain2_last", d, 32'h155);
    bus_read(6'd1, d); check("drain2_status", d, 32'h0);

    // Flush
    send_byte(8'h42, 1'b0);
    bus_read(6'd1, d); check("preflush_status", d, 32'h101);
    bus_write(6'd2, 32'h5);
    bus_read(6'd1, d); check("flush_status", d, 32'h0);
    bus_read(6'd2, d); check("flush_ctrl", d, 32'h1);

    // Reset in the middle of a frame
    send_byte(8'h99, 1'b0);
    bus_write(6'd2, 32'h3);
    repeat (2) @(negedge clk);
    check("pre_rst_irq", {31'd0, irq}, 32'h1);
    bus_read(6'd1, d); check("pre_rst_status", d, 32'h101);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    check("rst_rdata", rdata, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    repeat (BIT) @(negedge clk);
    bus_read(6'd2, d); check("rst_ctrl", d, 32'h1);
    bus_read(6'd1, d); check("rst_status", d, 32'h0);

    // Interrupt timing
    bus_write(6'd2, 32'h3);
    fork
      send_byte(8'h12, 1'b0);
      begin
        wait_push(found);
        check("irq_push_seen", {31'd0, found}, 32'h1);
        check("irq_before_push", {31'd0, irq}, 32'h0);
        @(negedge clk);
        check("irq_at_push", {31'd0, irq}, 32'h0);
        @(negedge clk);
        check("irq_after_push", {31'd0, irq}, 32'h1);
      end
    join
    bus_read(6'd0, d); check("rst_frame_rxdata", d, 32'h112);
    @(negedge clk);
    check("irq_after_pop", {31'd0, irq}, 32'h0);
    bus_read(6'd0, d); check("final_empty", d, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
